store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 31 +++
 rtl/store_fifo.sv | 82 ++++++++
 rtl/store_buffer.sv | 137 +++++++++++++
 tb/tb_store_buffer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: data types, size codes, the
// pointer reset value, the drain FSM state type and the size decoder.
package store_buffer_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;
  typedef logic [2:0]  nbytes_t;

  // st_size encodings; 2'd3 also decodes as a word store.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Reset value for the read/write pointers.
  localparam int NULL_PTR = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  function automatic nbytes_t size_to_nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Entry storage for the store buffer: a circular queue of {addr, data, nbytes}
// with wrapping pointers, an occupancy count and a per-slot occupied flag.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, pop         enqueue at tail / dequeue head (caller guarantees legality)
//   push_*            entry fields written on push
//   head_*            fields of the oldest entry
//   count             number of occupied entries (0..DEPTH)
//   occupied          one flag per slot, set while the slot holds an entry
//   entry_word        addr[31:2] of every slot, for the hazard compare
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [31:0]                push_addr,
  input  logic [31:0]                push_data,
  input  logic [2:0]                 push_nbytes,
  output logic [31:0]                head_addr,
  output logic [31:0]                head_data,
  output logic [2:0]                 head_nbytes,
  output logic [PTR_WIDTH:0]         count,
  output logic [DEPTH-1:0]           occupied,
  output logic [DEPTH-1:0][29:0]     entry_word
);

  addr_t   addr_mem   [DEPTH];
  word_t   data_mem   [DEPTH];
  nbytes_t nbytes_mem [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;

  assign head_addr   = addr_mem[rd_ptr];
  assign head_data   = data_mem[rd_ptr];
  assign head_nbytes = nbytes_mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_word[i] = addr_mem[i][31:2];
    end
  end

  // Push is refused when full and pop needs a non-empty queue, so a push and
  // a pop on the same edge never target the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= PTR_WIDTH'(NULL_PTR);
      rd_ptr   <= PTR_WIDTH'(NULL_PTR);
      count    <= '0;
      occupied <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]   <= '0;
        data_mem[i]   <= '0;
        nbytes_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wr_ptr]   <= push_addr;
        data_mem[wr_ptr]   <= push_data;
        nbytes_mem[wr_ptr] <= push_nbytes;
        occupied[wr_ptr]   <= 1'b1;
        wr_ptr             <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        occupied[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_WIDTH'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_WIDTH+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues stores from the load/store unit and drains them one
// byte per cycle through a shared byte memory port, with a word-granular
// load hazard check against every pending store.
// Handshake: a store is pushed on a rising edge where st_valid and st_ready
// are both high; st_ready never depends on st_valid.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   rdy                     global enable, low freezes all state
//   st_valid/st_ready       store request handshake
//   st_addr/st_data/st_size store byte address, data (LSB at addr), size code
//   chk_addr/chk_hit        load address and combinational overlap flag
//   empty                   nothing queued and nothing in flight
//   mem_req/mem_gnt         arbiter request/grant for the byte memory port
//   data_out/r_nw_out/addr_out  registered byte memory port
//   drain_state             current drain FSM state (0 = IDLE, 1 = WRITE)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [7:0]  data_out,
  output logic        r_nw_out,
  output logic [31:0] addr_out,
  output logic        drain_state
);

  localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

  drain_state_t state;
  logic [1:0]   cnt;

  logic                   push;
  logic                   pop;
  logic                   last_byte;
  logic [31:0]            head_addr;
  logic [31:0]            head_data;
  logic [2:0]             head_nbytes;
  logic [PTR_WIDTH:0]     count;
  logic [DEPTH-1:0]       occupied;
  logic [DEPTH-1:0][29:0] entry_word;

  // The hazard check is word granular; the byte offset is deliberately ignored.
  logic unused_chk_bits;
  assign unused_chk_bits = ^chk_addr[1:0];

  // Gated by rst so the buffer reads as not-ready while held in reset.
  assign st_ready = rst & rdy & (count < DEPTH_CNT);
  assign push     = st_valid & st_ready;

  assign last_byte = ({1'b0, cnt} == (head_nbytes - 3'd1));
  assign pop       = rdy & (state == WRITE) & last_byte;

  assign mem_req     = (state == WRITE) | (count != '0);
  assign empty       = (count == '0) & (state == IDLE);
  assign drain_state = state;

  store_fifo #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .push_addr   (st_addr),
    .push_data   (st_data),
    .push_nbytes (size_to_nbytes(st_size)),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .head_nbytes (head_nbytes),
    .count       (count),
    .occupied    (occupied),
    .entry_word  (entry_word)
  );

  // The head stays in the queue until its last byte goes out, so the entry
  // in flight is still covered by the occupied flags.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (entry_word[i] == chk_addr[31:2])) begin
        chk_hit = 1'b1;
      end
    end
  end

  // Each WRITE edge registers one byte; the grant edge only enters WRITE, so
  // the port shows idle values for at least one cycle between entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      r_nw_out <= 1'b1;
      addr_out <= '0;
      data_out <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          r_nw_out <= 1'b1;
          addr_out <= '0;
          data_out <= '0;
          if ((count != '0) && mem_gnt) begin
            state <= WRITE;
            cnt   <= 2'd0;
          end
        end
        WRITE: begin
          r_nw_out <= 1'b0;
          addr_out <= head_addr + {30'd0, cnt};
          data_out <= head_data[{cnt, 3'b000} +: 8];
          cnt      <= cnt + 2'd1;
          if (last_byte) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: write bytes are predicted when a store is accepted
// and matched in order as the memory port issues them, including the
// one-cycle gap between entries and back-to-back bytes within an entry.
module tb_store_buffer;
  import store_buffer_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic [31:0] chk_addr = '0;
  logic        chk_hit;
  logic        empty;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [7:0]  data_out;
  logic        r_nw_out;
  logic [31:0] addr_out;
  logic        drain_state;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .PTR_WIDTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .chk_addr    (chk_addr),
    .chk_hit     (chk_hit),
    .empty       (empty),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .data_out    (data_out),
    .r_nw_out    (r_nw_out),
    .addr_out    (addr_out),
    .drain_state (drain_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  // {first byte of entry, byte address, byte data}
  logic [40:0] exp_q[$];
  int   cyc = 0;
  int   last_wr_cyc = -10;
  int   writes_seen = 0;
  logic edge_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size);
    int n;
    logic [31:0] d;
    n = (size == SIZE_B) ? 1 : (size == SIZE_H) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      d = data >> (8 * k);
      exp_q.push_back({(k == 0), addr + 32'(k), d[7:0]});
    end
  endtask

  // Count only edges where the DUT was allowed to advance.
  always @(posedge clk) begin
    edge_en = rst & rdy;
    if (rst && rdy) cyc = cyc + 1;
  end

  always @(negedge clk) begin
    logic [40:0] e;
    if (rst && edge_en && !r_nw_out) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", addr_out, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", addr_out, e[39:8]);
        check("wr_data", {24'd0, data_out}, {24'd0, e[7:0]});
        if (e[40]) check("entry_gap", 32'(cyc > last_wr_cyc + 1), 32'd1);
        else       check("byte_consecutive", 32'(cyc == last_wr_cyc + 1), 32'd1);
      end
      last_wr_cyc = cyc;
    end
  end

  // ---------------- driver tasks (start/end at posedge + #1) ----------------
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size);
    int n = 0;
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    st_size  = size;
    #0;
    while (!st_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("store_accept", {31'd0, st_ready}, 32'd1);
    if (st_ready) push_expected(addr, data, size);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(empty && exp_q.size() == 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", {31'd0, (empty && exp_q.size() == 0)}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Returns at the negedge where the first write byte is visible.
  task automatic wait_write();
    int n = 0;
    @(negedge clk);
    while (r_nw_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("write_seen", {31'd0, r_nw_out}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] chk;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    tbl[0] = '{32'h0000_0100, 32'hDDCC_BBAA, SIZE_W, 32'h0000_0103, 1'b1};
    tbl[1] = '{32'h0000_0206, 32'h0000_BEEF, SIZE_H, 32'h0000_0204, 1'b1};
    tbl[2] = '{32'h0000_0206, 32'h0000_BEEF, SIZE_H, 32'h0000_0208, 1'b0};
    tbl[3] = '{32'h0000_00FF, 32'h1122_3344, SIZE_B, 32'h0000_00FC, 1'b1};
    tbl[4] = '{32'h0000_0402, 32'h8765_4321, SIZE_W, 32'h0000_0404, 1'b0};
    tbl[5] = '{32'h0000_07FC, 32'hCAFE_F00D, 2'd3,   32'h0000_07FF, 1'b1};
    tbl[6] = '{32'h0000_0010, 32'hAAAA_5555, SIZE_H, 32'h0000_0014, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_st_ready", {31'd0, st_ready}, 32'd0);
    check("rst_empty",    {31'd0, empty},    32'd1);
    check("rst_mem_req",  {31'd0, mem_req},  32'd0);
    check("rst_r_nw",     {31'd0, r_nw_out}, 32'd1);
    check("rst_addr",     addr_out,          32'd0);
    check("rst_data",     {24'd0, data_out}, 32'd0);
    check("rst_chk_hit",  {31'd0, chk_hit},  32'd0);
    check("rst_state",    {31'd0, drain_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Word store drains as 4 consecutive bytes, then empty
    mem_gnt = 1'b1;
    do_store(32'h100, 32'hDDCC_BBAA, SIZE_W);
    wait_write();
    check("w_b0_addr", addr_out, 32'h100);
    check("w_b0_data", {24'd0, data_out}, 32'hAA);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("w_bn_rnw",  {31'd0, r_nw_out}, 32'd0);
      check("w_bn_addr", addr_out, 32'h100 + 32'(k));
    end
    check("w_last_data", {24'd0, data_out}, 32'hDD);
    check("w_empty", {31'd0, empty}, 32'd1);
    @(posedge clk); #1;
    wait_drain();

    // Fill: 4 accepted, 5th refused, no write without grant
    mem_gnt = 1'b0;
    ws = writes_seen;
    for (int i = 0; i < 4; i++) do_store(32'h40 + 32'(i), 32'(i + 1), SIZE_B);
    st_valid = 1'b1;
    st_addr  = 32'h44;
    st_data  = 32'h55;
    st_size  = SIZE_B;
    #1;
    check("fill_ready", {31'd0, st_ready}, 32'd0);
    check("fill_req",   {31'd0, mem_req},  32'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("fill_ready_hold", {31'd0, st_ready}, 32'd0);
    st_valid = 1'b0;
    check("fill_no_write", 32'(writes_seen), 32'(ws));
    check("fill_rnw", {31'd0, r_nw_out}, 32'd1);
    mem_gnt = 1'b1;
    wait_drain();
    check("fill_drained_count", 32'(writes_seen - ws), 32'd4);

    // Hazard on a pending half store
    mem_gnt = 1'b0;
    do_store(32'h206, 32'h0000_BEEF, SIZE_H);
    chk_addr = 32'h204; #1;
    check("haz_hit", {31'd0, chk_hit}, 32'd1);
    chk_addr = 32'h208; #1;
    check("haz_miss", {31'd0, chk_hit}, 32'd0);
    mem_gnt = 1'b1;
    wait_drain();
    chk_addr = 32'h204; #1;
    check("haz_after_drain", {31'd0, chk_hit}, 32'd0);

    // Table of single stores with a hazard probe each
    for (int i = 0; i < 7; i++) begin
      mem_gnt = 1'b0;
      do_store(tbl[i].addr, tbl[i].data, tbl[i].size);
      chk_addr = tbl[i].chk; #1;
      check("tbl_hit", {31'd0, chk_hit}, {31'd0, tbl[i].exp_hit});
      check("tbl_req", {31'd0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      wait_drain();
      check("tbl_hit_after", {31'd0, chk_hit}, 32'd0);
    end

    // rdy low for 3 cycles after the first byte freezes the port
    mem_gnt = 1'b1;
    do_store(32'h500, 32'h4433_2211, SIZE_W);
    wait_write();
    check("rdy_b0_addr", addr_out, 32'h500);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rdy_hold_addr",  addr_out, 32'h500);
      check("rdy_hold_data",  {24'd0, data_out}, 32'h11);
      check("rdy_hold_rnw",   {31'd0, r_nw_out}, 32'd0);
      check("rdy_st_ready",   {31'd0, st_ready}, 32'd0);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    wait_drain();

    // Reset in the middle of a word store
    do_store(32'h600, 32'h8877_6655, SIZE_W);
    wait_write();
    @(negedge clk);
    check("rstw_b1_addr", addr_out, 32'h601);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("rstw_rnw",      {31'd0, r_nw_out}, 32'd1);
    check("rstw_addr",     addr_out, 32'd0);
    check("rstw_data",     {24'd0, data_out}, 32'd0);
    check("rstw_empty",    {31'd0, empty}, 32'd1);
    check("rstw_mem_req",  {31'd0, mem_req}, 32'd0);
    check("rstw_st_ready", {31'd0, st_ready}, 32'd0);
    ws = writes_seen;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rstw_no_more_writes", 32'(writes_seen), 32'(ws));
    check("rstw_empty_after", {31'd0, empty}, 32'd1);

    // Ten byte stores wrap the pointers
    ws = writes_seen;
    for (int i = 0; i < 10; i++) do_store(32'h300 + 32'(i), 32'hA0 + 32'(i), SIZE_B);
    wait_drain();
    check("wrap_count", 32'(writes_seen - ws), 32'd10);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
